// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the write-back cache controller.
// Address layout: [1:0] byte, [3:2] word, [IDX+3:4] index, top TAG_BITS tag.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_RESPOND
  } state_t;

  localparam int WORD_LSB = 2;
  localparam int IDX_LSB  = 4;

  function automatic int tag_lsb(input int idx_bits);
    return IDX_LSB + idx_bits;
  endfunction

  function automatic logic [1:0] addr_word(input logic [31:0] addr);
    return addr[WORD_LSB +: 2];
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_bits);
    return (addr >> IDX_LSB) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_bits);
    return addr >> tag_lsb(idx_bits);
  endfunction

endpackage

// File: rtl/cache_shadow_dir.sv
// Shadow directory: per-line valid/dirty/tag, mirroring what the cache array
// holds so the controller knows whether and where to write back a victim.
module cache_shadow_dir #(
  parameter  int LINES    = 32,
  parameter  int TAG_BITS = 6,
  localparam int IDX      = $clog2(LINES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX-1:0]      idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_BITS-1:0] rd_tag,
  input  logic                set_dirty,
  input  logic                clr_dirty,
  input  logic                fill,
  input  logic [TAG_BITS-1:0] fill_tag
);

  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic [TAG_BITS-1:0] tag_q [LINES];
  logic [TAG_BITS-1:0] tag_d [LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];

  // NOTE: start from the current state so every path assigns; no latches.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (fill) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
      tag_d[idx]   = fill_tag;
    end
    if (set_dirty) dirty_d[idx] = 1'b1;
    if (clr_dirty) dirty_d[idx] = 1'b0;
  end

  // NOTE: this small directory is flops, so it is cleared on reset; a RAM-based
  // store would clear only the valid bits. Sequential state uses <= only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Write-back, write-allocate controller for a direct-mapped cache array:
// FSM, request latch, saturating hit/miss counters and the shadow directory.
module cache_controller
  import cache_pkg::*;
#(
  parameter  int LINES      = 32,
  parameter  int TAG_BITS   = 6,
  parameter  int BLOCK_BITS = 256,
  parameter  int CNT_BITS   = 16,
  localparam int IDX        = $clog2(LINES),
  localparam int AW         = TAG_BITS + IDX + IDX_LSB
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [AW-1:0]             cpu_addr,
  input  logic [31:0]               cpu_wdata,
  output logic                      cpu_ready,
  output logic [31:0]               cpu_rdata,
  output logic [TAG_BITS-1:0]       c_tag,
  output logic [IDX-1:0]            c_index,
  output logic [1:0]                c_word_sel,
  output logic                      c_write_en,
  output logic [31:0]               c_write_data,
  output logic                      c_load_line,
  output logic [BLOCK_BITS-1:0]     c_block_in,
  input  logic                      c_hit,
  input  logic [31:0]               c_read_word,
  input  logic [BLOCK_BITS-1:0]     c_block_out,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [TAG_BITS+IDX-1:0]   mem_addr,
  output logic [BLOCK_BITS-1:0]     mem_wdata,
  input  logic [BLOCK_BITS-1:0]     mem_rdata,
  input  logic                      mem_ack,
  output logic [CNT_BITS-1:0]       hit_count,
  output logic [CNT_BITS-1:0]       miss_count
);

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                refill_q, refill_d;
  logic [CNT_BITS-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_BITS-1:0] miss_cnt_q, miss_cnt_d;

  logic [31:0]         addr_ext;
  logic [IDX-1:0]      idx;
  logic [TAG_BITS-1:0] tag;
  logic                sd_valid, sd_dirty;
  logic [TAG_BITS-1:0] sd_tag;
  logic                set_dirty, clr_dirty, fill;

  assign addr_ext = 32'(addr_q);
  assign idx      = IDX'(addr_index(addr_ext, IDX));
  assign tag      = TAG_BITS'(addr_tag(addr_ext, IDX));

  cache_shadow_dir #(
    .LINES    (LINES),
    .TAG_BITS (TAG_BITS)
  ) u_dir (
    .clk       (clk),
    .reset     (reset),
    .idx       (idx),
    .rd_valid  (sd_valid),
    .rd_dirty  (sd_dirty),
    .rd_tag    (sd_tag),
    .set_dirty (set_dirty),
    .clr_dirty (clr_dirty),
    .fill      (fill),
    .fill_tag  (tag)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (cpu_req) state_d = S_COMPARE;
      S_COMPARE: begin
        if (c_hit)                     state_d = S_RESPOND;
        else if (sd_valid && sd_dirty) state_d = S_WRITEBACK;
        else                           state_d = S_ALLOCATE;
      end
      S_WRITEBACK: if (mem_ack) state_d = S_ALLOCATE;
      S_ALLOCATE:  if (mem_ack) state_d = S_COMPARE;
      S_RESPOND:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Cache-side and memory-side strobes are combinational so a zero-wait ack
  // completes in the state's first cycle.
  always_comb begin
    c_write_en  = 1'b0;
    c_load_line = 1'b0;
    c_block_in  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    set_dirty   = 1'b0;
    clr_dirty   = 1'b0;
    fill        = 1'b0;
    unique case (state_q)
      S_COMPARE: begin
        if (c_hit && we_q) begin
          c_write_en = 1'b1;
          set_dirty  = 1'b1;
        end
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {sd_tag, idx};
        mem_wdata = c_block_out;
        clr_dirty = mem_ack;
      end
      S_ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {tag, idx};
        if (mem_ack) begin
          c_load_line = 1'b1;
          c_block_in  = mem_rdata;
          fill        = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign c_tag        = tag;
  assign c_index      = idx;
  assign c_word_sel   = addr_word(addr_ext);
  assign c_write_data = wdata_q;
  assign cpu_ready    = ready_q;
  assign cpu_rdata    = rdata_q;
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;

  always_comb begin
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    refill_d   = refill_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    // Registered so the completion pulse lands three cycles after the request.
    ready_d    = (state_q == S_RESPOND);
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
        end
      end
      S_COMPARE: begin
        if (c_hit) begin
          if (!we_q) rdata_d = c_read_word;
          // The re-compare after a refill completes an access already counted as a miss.
          if (!refill_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_BITS'(1);
        end else if (miss_cnt_q != '1) begin
          miss_cnt_d = miss_cnt_q + CNT_BITS'(1);
        end
      end
      S_ALLOCATE: if (mem_ack) refill_d = 1'b1;
      S_RESPOND:  refill_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural direct-mapped cache array, memory
// with random ack delay, table of CPU accesses plus reset/saturation sequences.
module tb_cache_controller;

  localparam int LINES = 32;
  localparam int TB    = 6;
  localparam int BB    = 256;
  localparam int CB    = 8;
  localparam int IDX   = 5;
  localparam int AW    = TB + IDX + 4;
  localparam int MAW   = TB + IDX;

  logic           clk = 1'b0;
  logic           reset;
  logic           cpu_req, cpu_we;
  logic [AW-1:0]  cpu_addr;
  logic [31:0]    cpu_wdata;
  logic           cpu_ready;
  logic [31:0]    cpu_rdata;
  logic [TB-1:0]  c_tag;
  logic [IDX-1:0] c_index;
  logic [1:0]     c_word_sel;
  logic           c_write_en;
  logic [31:0]    c_write_data;
  logic           c_load_line;
  logic [BB-1:0]  c_block_in;
  logic           c_hit;
  logic [31:0]    c_read_word;
  logic [BB-1:0]  c_block_out;
  logic           mem_req, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [BB-1:0]  mem_wdata;
  logic [BB-1:0]  mem_rdata;
  logic           mem_ack;
  logic [CB-1:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  cache_controller #(
    .LINES(LINES), .TAG_BITS(TB), .BLOCK_BITS(BB), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .c_tag(c_tag), .c_index(c_index), .c_word_sel(c_word_sel),
    .c_write_en(c_write_en), .c_write_data(c_write_data),
    .c_load_line(c_load_line), .c_block_in(c_block_in),
    .c_hit(c_hit), .c_read_word(c_read_word), .c_block_out(c_block_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // ---------------- behavioural cache array ----------------
  logic          cache_rst;
  logic [TB-1:0] ct [LINES];
  logic          cv [LINES];
  logic [BB-1:0] cd [LINES];

  assign cache_rst   = !reset;
  assign c_hit       = cv[c_index] && (ct[c_index] == c_tag);
  assign c_read_word = cd[c_index][{c_word_sel, 5'b0} +: 32];
  assign c_block_out = cd[c_index];

  always @(posedge clk or posedge cache_rst) begin
    if (cache_rst) begin
      for (int i = 0; i < LINES; i++) begin
        cv[i] <= 1'b0; ct[i] <= '0; cd[i] <= '0;
      end
    end else if (c_load_line) begin
      cv[c_index] <= 1'b1;
      ct[c_index] <= c_tag;
      cd[c_index] <= c_block_in;
    end else if (c_write_en) begin
      cd[c_index][{c_word_sel, 5'b0} +: 32] <= c_write_data;
    end
  end

  // ---------------- behavioural memory ----------------
  typedef struct { logic [MAW-1:0] a; logic [127:0] d; } wb_t;

  logic [BB-1:0]  mem_store [logic [MAW-1:0]];
  wb_t            wb_q[$];
  logic [MAW-1:0] fetch_q[$];
  logic           resp_ack, spur_ack, mem_stall;
  int             wait_cnt, max_delay;

  assign mem_ack = resp_ack | spur_ack;

  function automatic logic [31:0] pat(input logic [MAW-1:0] blk, input logic [1:0] w);
    return 32'hA500_0000 | ({21'd0, blk} << 8) | {30'd0, w};
  endfunction

  function automatic logic [BB-1:0] fetch_blk(input logic [MAW-1:0] a);
    logic [BB-1:0] b;
    if (mem_store.exists(a)) return mem_store[a];
    for (int w = 0; w < 8; w++) b[w*32 +: 32] = pat(a, 2'(w)) ^ ((w >= 4) ? 32'h00FF_0000 : 32'h0);
    return b;
  endfunction

  initial begin
    resp_ack = 1'b0; mem_rdata = '0; wait_cnt = 0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (mem_req && reset && !mem_stall) begin
        if (wait_cnt == 0) begin
          resp_ack = 1'b1;
          if (mem_we) begin
            mem_store[mem_addr] = mem_wdata;
            wb_q.push_back('{a: mem_addr, d: mem_wdata[127:0]});
          end else begin
            mem_rdata = fetch_blk(mem_addr);
            fetch_q.push_back(mem_addr);
          end
          wait_cnt = $urandom_range(max_delay, 0);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int             load_line_cnt = 0;
  int             stab_err = 0;
  logic           ack_at_edge = 1'b0;
  logic           prev_req = 1'b0, prev_we = 1'b0;
  logic [MAW-1:0] prev_addr = '0;
  logic [BB-1:0]  prev_wd = '0;

  always @(posedge clk) begin
    if (c_load_line) load_line_cnt++;
    ack_at_edge = mem_ack;
  end

  always @(negedge clk) begin
    if (prev_req && mem_req && !ack_at_edge &&
        (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wd))
      stab_err++;
    prev_req = mem_req; prev_addr = mem_addr; prev_we = mem_we; prev_wd = mem_wdata;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] ref_mem [logic [12:0]];

  function automatic logic [31:0] ref_word(input logic [12:0] k);
    if (ref_mem.exists(k)) return ref_mem[k];
    return pat(k[12:2], k[1:0]);
  endfunction

  typedef struct { bit is_load; logic [31:0] data; } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic           we;
    logic [AW-1:0]  addr;
    logic [31:0]    wdata;
    bit             miss;
    bit             wb;
    logic [MAW-1:0] wb_blk;
  } vec_t;

  int exp_h = 0, exp_m = 0;

  task automatic do_access(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output bit timed_out);
    bit done;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk);
    cpu_req = 1'b0;
    lat = 1; timed_out = 1'b1; rd = '0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (cpu_ready) begin
        timed_out = 1'b0; rd = cpu_rdata; done = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int             lat, wb0, f0, ll0;
    logic [31:0]    rd;
    bit             to;
    exp_t           e;
    logic [127:0]   exp_blk;
    wb_t            got_wb;
    logic [MAW-1:0] got_f;
    wb0 = wb_q.size(); f0 = fetch_q.size(); ll0 = load_line_cnt;
    exp_blk = '0;
    if (v.wb) for (int w = 0; w < 4; w++) exp_blk[w*32 +: 32] = ref_word({v.wb_blk, 2'(w)});
    e.is_load = !v.we;
    e.data    = ref_word(v.addr[AW-1:2]);
    sb_q.push_back(e);
    if (v.we) ref_mem[v.addr[AW-1:2]] = v.wdata;
    if (v.miss) exp_m = (exp_m == 255) ? 255 : exp_m + 1;
    else        exp_h = (exp_h == 255) ? 255 : exp_h + 1;

    do_access(v.we, v.addr, v.wdata, lat, rd, to);
    check({nm, " timeout"}, 128'(to), 128'(0));
    e = sb_q.pop_front();
    if (e.is_load) check({nm, " rdata"}, 128'(rd), 128'(e.data));
    check({nm, " hit_count"}, 128'(hit_count), 128'(exp_h));
    check({nm, " miss_count"}, 128'(miss_count), 128'(exp_m));
    if (!v.miss) check({nm, " hit latency"}, 128'(lat), 128'(3));
    check({nm, " writebacks"}, 128'(wb_q.size() - wb0), 128'(v.wb));
    if (v.wb && wb_q.size() > wb0) begin
      got_wb = wb_q[wb0];
      check({nm, " wb addr"}, 128'(got_wb.a), 128'(v.wb_blk));
      check({nm, " wb data"}, got_wb.d, exp_blk);
    end
    check({nm, " fetches"}, 128'(fetch_q.size() - f0), 128'(v.miss));
    if (v.miss && fetch_q.size() > f0) begin
      got_f = fetch_q[f0];
      check({nm, " fetch addr"}, 128'(got_f), 128'(v.addr[AW-1:4]));
    end
    check({nm, " load_line pulses"}, 128'(load_line_cnt - ll0), 128'(v.miss));
    @(negedge clk);
    check({nm, " ready single pulse"}, 128'(cpu_ready), 128'(0));
  endtask

  vec_t vecs [13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_ready;
    vec_t v;
    vecs[0]  = '{1'b0, 15'h0124, 32'h0,        1'b1, 1'b0, 11'h000};
    vecs[1]  = '{1'b1, 15'h0124, 32'hDEADBEEF, 1'b0, 1'b0, 11'h000};
    vecs[2]  = '{1'b0, 15'h0124, 32'h0,        1'b0, 1'b0, 11'h000};
    vecs[3]  = '{1'b1, 15'h0124, 32'hDEADBEEF, 1'b0, 1'b0, 11'h000};
    vecs[4]  = '{1'b0, 15'h2124, 32'h0,        1'b1, 1'b1, 11'h012};
    vecs[5]  = '{1'b0, 15'h0120, 32'h0,        1'b1, 1'b0, 11'h000};
    vecs[6]  = '{1'b0, 15'h0124, 32'h0,        1'b0, 1'b0, 11'h000};
    vecs[7]  = '{1'b1, 15'h0348, 32'hCAFEF00D, 1'b1, 1'b0, 11'h000};
    vecs[8]  = '{1'b0, 15'h0348, 32'h0,        1'b0, 1'b0, 11'h000};
    vecs[9]  = '{1'b0, 15'h2348, 32'h0,        1'b1, 1'b1, 11'h034};
    vecs[10] = '{1'b0, 15'h034C, 32'h0,        1'b1, 1'b0, 11'h000};
    vecs[11] = '{1'b0, 15'h0348, 32'h0,        1'b0, 1'b0, 11'h000};
    vecs[12] = '{1'b0, 15'h034B, 32'h0,        1'b0, 1'b0, 11'h000};

    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    spur_ack = 1'b0; mem_stall = 1'b0; max_delay = 5;
    #13;
    check("reset cpu_ready", 128'(cpu_ready), 128'(0));
    check("reset cpu_rdata", 128'(cpu_rdata), 128'(0));
    check("reset mem_req", 128'(mem_req), 128'(0));
    check("reset mem_addr", 128'(mem_addr), 128'(0));
    check("reset c_write_en", 128'(c_write_en), 128'(0));
    check("reset c_load_line", 128'(c_load_line), 128'(0));
    check("reset hit_count", 128'(hit_count), 128'(0));
    check("reset miss_count", 128'(miss_count), 128'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while ALLOCATE is waiting on memory.
    mem_stall = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0524;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int c = 0; c < 20 && !mem_req; c++) @(negedge clk);
    check("alloc mem_req", 128'(mem_req), 128'(1));
    check("alloc mem_we", 128'(mem_we), 128'(0));
    check("alloc mem_addr", 128'(mem_addr), 128'(11'h052));
    #2 reset = 1'b0;
    #1;
    check("midreset mem_req", 128'(mem_req), 128'(0));
    check("midreset hit_count", 128'(hit_count), 128'(0));
    check("midreset miss_count", 128'(miss_count), 128'(0));
    seen_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cpu_ready) seen_ready = 1'b1;
    end
    reset = 1'b1; mem_stall = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (cpu_ready) seen_ready = 1'b1;
    end
    check("no ready after reset", 128'(seen_ready), 128'(0));
    exp_h = 0; exp_m = 0;
    v = '{1'b0, 15'h0124, 32'h0, 1'b1, 1'b0, 11'h000};
    run_vec(v, "post-reset load");

    // Spurious ack in IDLE.
    @(negedge clk);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    check("spurious mem_req", 128'(mem_req), 128'(0));
    check("spurious cpu_ready", 128'(cpu_ready), 128'(0));
    check("spurious hit_count", 128'(hit_count), 128'(exp_h));
    check("spurious miss_count", 128'(miss_count), 128'(exp_m));
    v = '{1'b0, 15'h0124, 32'h0, 1'b0, 1'b0, 11'h000};
    run_vec(v, "after spurious");

    // 300 misses: alternate tags on index 5 to force a miss every time.
    max_delay = 2;
    for (int i = 0; i < 300; i++) begin
      v.we = 1'b0; v.wdata = '0; v.miss = 1'b1; v.wb = 1'b0; v.wb_blk = '0;
      v.addr = {((i % 2 == 0) ? 6'd3 : 6'd4), 5'd5, 4'h0};
      run_vec(v, $sformatf("sat%0d", i));
    end
    check("miss_count saturated", 128'(miss_count), 128'(8'hFF));
    check("mem signals stable while req", 128'(stab_err), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
